// File: rtl/gbe_orun_status_ctrl.sv
// Overrun event counter/status block for 10GbE cores: counts rising edges of each
// channel's overrun level, with arm/clear/freeze control and a packed status word.
module gbe_orun_status_ctrl #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 7
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [NUM_CH-1:0] orun_in,
    input  logic [31:0]       ctrl_in,
    output logic [31:0]       user_data_out,
    output logic              frozen
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_FROZEN   = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              rst_meta_q;
    logic              rst_sync_q;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] orun_q;
    logic              clr_q;
    logic [31:0]       data_q, data_d;
    logic              frozen_q, frozen_d;

    logic              arm;
    logic              clr_lvl;
    logic              freeze_on_sat;
    logic              clr_edge;
    logic [NUM_CH-1:0] evt;
    logic              hit_max;
    logic              unused_ctrl;

    assign arm           = ctrl_in[0];
    assign clr_lvl       = ctrl_in[1];
    assign freeze_on_sat = ctrl_in[2];
    assign unused_ctrl   = ^ctrl_in[31:3];

    assign evt      = orun_in & ~orun_q;
    assign clr_edge = clr_lvl & ~clr_q;

    // Reset asserts immediately but releases two user_clk edges after user_rst_n rises.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        hit_max = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (clr_edge) begin
            // An event landing with the clear still counts when the block stays armed.
            state_d = arm ? ST_ARMED : ST_DISARMED;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_d[i] = (arm && evt[i]) ? CNT_ONE : '0;
            end
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (!arm) begin
                        state_d = ST_DISARMED;
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (evt[i] && (cnt_q[i] != CNT_MAX)) begin
                                cnt_d[i] = cnt_q[i] + CNT_ONE;
                                if (cnt_q[i] == CNT_MAX_M1) begin
                                    hit_max = 1'b1;
                                end
                            end
                        end
                        if (freeze_on_sat && hit_max) begin
                            state_d = ST_FROZEN;
                        end
                    end
                end
                ST_FROZEN: begin
                    state_d = ST_FROZEN;
                end
                default: begin
                    state_d = arm ? ST_ARMED : ST_DISARMED;
                end
            endcase
        end
    end

    // Status word is built from the registered counters and state, one edge behind them.
    always_comb begin
        data_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            data_d[i*CNT_W +: CNT_W] = cnt_q[i];
        end
        data_d[31:30] = (state_q == ST_FROZEN) ? 2'b10 :
                        (state_q == ST_ARMED)  ? 2'b01 : 2'b00;
        frozen_d = (state_q == ST_FROZEN);
    end

    always_ff @(posedge user_clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q  <= ST_DISARMED;
            orun_q   <= '0;
            clr_q    <= 1'b0;
            data_q   <= '0;
            frozen_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            orun_q   <= orun_in;
            clr_q    <= clr_lvl;
            data_q   <= data_d;
            frozen_q <= frozen_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign user_data_out = data_q;
    assign frozen        = frozen_q;

endmodule

// File: tb/tb_gbe_orun_status_ctrl.sv
// Directed bench for gbe_orun_status_ctrl: an integer-level model of the counters and
// control states predicts the status word, checked every cycle plus literal pins.
module tb_gbe_orun_status_ctrl;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 7;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic              user_clk   = 1'b0;
    logic              user_rst_n = 1'b0;
    logic [NUM_CH-1:0] orun_in    = '0;
    logic [31:0]       ctrl_in    = '0;
    logic [31:0]       user_data_out;
    logic              frozen;

    int n_vec = 0;
    int n_err = 0;

    always #5 user_clk = ~user_clk;

    gbe_orun_status_ctrl #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .user_clk     (user_clk),
        .user_rst_n   (user_rst_n),
        .orun_in      (orun_in),
        .ctrl_in      (ctrl_in),
        .user_data_out(user_data_out),
        .frozen       (frozen)
    );

    // Model state: mode 0 = disarmed, 1 = armed, 2 = frozen.
    int                m_cnt [NUM_CH] = '{default: 0};
    int                m_mode         = 0;
    int                m_rel          = 0;
    logic [NUM_CH-1:0] m_prev_orun    = '0;
    logic              m_prev_clr     = 1'b0;
    logic [31:0]       exp_word       = '0;
    logic              exp_frozen     = 1'b0;

    function automatic logic [31:0] pack_word(input int c [NUM_CH], input int mode);
        logic [31:0] w;
        w = 32'(mode) << 30;
        for (int i = 0; i < NUM_CH; i++) begin
            w = w + (32'(c[i]) << (i * CNT_W));
        end
        return w;
    endfunction

    always @(posedge user_clk or negedge user_rst_n) begin : model
        int                nc [NUM_CH];
        int                nm;
        logic              sat;
        logic [NUM_CH-1:0] ev;
        logic              clr;
        if (!user_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) m_cnt[i] <= 0;
            m_mode      <= 0;
            m_rel       <= 0;
            m_prev_orun <= '0;
            m_prev_clr  <= 1'b0;
            exp_word    <= '0;
            exp_frozen  <= 1'b0;
        end else if (m_rel < 2) begin
            m_rel <= m_rel + 1;
        end else begin
            exp_word   <= pack_word(m_cnt, m_mode);
            exp_frozen <= (m_mode == 2);
            ev  = orun_in & ~m_prev_orun;
            clr = ctrl_in[1] & ~m_prev_clr;
            nc  = m_cnt;
            nm  = m_mode;
            sat = 1'b0;
            if (clr) begin
                nm = ctrl_in[0] ? 1 : 0;
                for (int i = 0; i < NUM_CH; i++) nc[i] = (nm == 1 && ev[i]) ? 1 : 0;
            end else if (m_mode == 1) begin
                if (!ctrl_in[0]) begin
                    nm = 0;
                end else begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ev[i] && nc[i] < MAXV) begin
                            nc[i] = nc[i] + 1;
                            if (nc[i] == MAXV) sat = 1'b1;
                        end
                    end
                    if (ctrl_in[2] && sat) nm = 2;
                end
            end else if (m_mode == 0) begin
                if (ctrl_in[0]) nm = 1;
            end
            m_cnt       <= nc;
            m_mode      <= nm;
            m_prev_orun <= orun_in;
            m_prev_clr  <= ctrl_in[1];
        end
    end

    task automatic check(input string name, input logic [31:0] w, input logic f);
        n_vec++;
        if (user_data_out !== w || frozen !== f) begin
            n_err++;
            $display("FAIL %s: got word=%h frozen=%b, expected word=%h frozen=%b",
                     name, user_data_out, frozen, w, f);
        end
    endtask

    task automatic step();
        @(negedge user_clk);
        check("model_cycle", exp_word, exp_frozen);
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] m);
        orun_in = m;
        step();
        orun_in = '0;
        step();
    endtask

    task automatic release_reset();
        user_rst_n = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        repeat (2) step();
        release_reset();
        check("reset_word", 32'h0000_0000, 1'b0);

        ctrl_in = 32'h1;
        step();
        repeat (3) pulse(4'b0001);
        check("arm_three_pulses", 32'h4000_0003, 1'b0);

        pulse(4'b1111);
        pulse(4'b0110);
        check("multi_channel", 32'h4020_8104, 1'b0);

        ctrl_in = 32'h3;
        step();
        ctrl_in = 32'h1;
        step();
        check("clear_armed", 32'h4000_0000, 1'b0);

        repeat (130) pulse(4'b0001);
        check("sat_no_freeze", 32'h4000_007F, 1'b0);

        ctrl_in = 32'h2;
        step();
        ctrl_in = 32'h0;
        step();
        check("clear_disarmed", 32'h0000_0000, 1'b0);

        // ch2 saturated at 127 sits at bits [20:14].
        ctrl_in = 32'h5;
        step();
        repeat (130) pulse(4'b0100);
        check("sat_freeze", 32'h801F_C000, 1'b1);
        repeat (3) pulse(4'b1111);
        check("frozen_ignores_events", 32'h801F_C000, 1'b1);
        ctrl_in = 32'h1;
        repeat (2) step();
        ctrl_in = 32'h0;
        step();
        check("frozen_ignores_arm", 32'h801F_C000, 1'b1);

        ctrl_in = 32'h5;
        step();
        ctrl_in = 32'h7;
        orun_in = 4'b0010;
        step();
        orun_in = '0;
        step();
        check("clear_with_event", 32'h4000_0080, 1'b0);

        repeat (2) pulse(4'b1111);
        check("count_before_reset", 32'h4040_8182, 1'b0);
        #2 user_rst_n = 1'b0;
        #1 check("async_reset", 32'h0000_0000, 1'b0);
        step();
        ctrl_in = 32'h0;
        step();
        release_reset();

        repeat (5) pulse(4'b1111);
        check("disarmed_ignore", 32'h0000_0000, 1'b0);
        ctrl_in = 32'h1;
        repeat (2) step();
        orun_in = 4'b1000;
        repeat (10) step();
        orun_in = '0;
        step();
        check("level_counts_once", 32'h4020_0000, 1'b0);

        user_rst_n = 1'b0;
        orun_in    = 4'b0001;
        repeat (2) step();
        release_reset();
        step();
        orun_in = '0;
        step();
        check("high_at_release", 32'h4000_0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
